// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared constants and types for the fetch stage and its IF/ID register.
package if_fetch_pkg;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } if_state_e;
  typedef enum logic [1:0] {
    IDC_HOLD,
    IDC_LOAD,
    IDC_BUBBLE
  } id_ctl_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ds;
  } if_id_t;
endpackage

// File: rtl/if_fetch_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and bubble control.
module if_id_reg
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = ZERO_WORD
) (
  input  logic    clk,
  input  logic    rst,
  input  id_ctl_e ctl_i,
  input  if_id_t  d_i,
  output if_id_t  q_o
);
  localparam if_id_t BUBBLE = '{pc: ZERO_WORD, inst: NOP_INST, ds: 1'b0};
  if_id_t q_q, q_d;
  always_comb q_d = (ctl_i == IDC_LOAD) ? d_i : (ctl_i == IDC_BUBBLE) ? BUBBLE : q_q;
  always_ff @(posedge clk) q_q <= rst ? BUBBLE : q_d;
  assign q_o = q_q;
endmodule

// File: rtl/if_fetch.sv
// if_fetch: PC/fetch FSM with one-delay-slot branch redirect, feeding the IF/ID register.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = ZERO_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic        next_inst_in_delayslot_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_is_in_delayslot_o,
  output logic [31:0] pc_o
);
  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d, redirect_addr_q, redirect_addr_d;
  logic [31:0] hold_pc_q, hold_pc_d, hold_inst_q, hold_inst_d;
  logic        redirect_pend_q, redirect_pend_d, ds_pend_q, ds_pend_d;
  logic        br, eff_ds;
  logic [31:0] next_pc;
  id_ctl_e     id_ctl;
  if_id_t      id_d, id_q;
  assign br = branch_flag_i & ~stall_i;
  // A branch resolved in the same cycle the delay slot lands takes effect immediately.
  assign eff_ds = br ? next_inst_in_delayslot_i : ds_pend_q;
  assign next_pc = br ? branch_target_address_i : redirect_pend_q ? redirect_addr_q : pc_q + PC_STEP;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    redirect_pend_d = redirect_pend_q;
    redirect_addr_d = redirect_addr_q;
    ds_pend_d = ds_pend_q;
    hold_pc_d = hold_pc_q;
    hold_inst_d = hold_inst_q;
    imem_req_o = 1'b0;
    id_ctl = IDC_HOLD;
    id_d = '{pc: hold_pc_q, inst: hold_inst_q, ds: eff_ds};
    if (br) begin
      redirect_pend_d = 1'b1;
      redirect_addr_d = branch_target_address_i;
      ds_pend_d = next_inst_in_delayslot_i;
    end
    case (state_q)
      S_RESET: begin
        state_d = S_FETCH;
        id_ctl = stall_i ? IDC_HOLD : IDC_BUBBLE;
      end
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_valid_i) begin
          pc_d = next_pc;
          redirect_pend_d = 1'b0;
          if (stall_i) begin
            hold_pc_d = pc_q;
            hold_inst_d = imem_rdata_i;
            state_d = S_HOLD;
          end else begin
            id_ctl = IDC_LOAD;
            id_d = '{pc: pc_q, inst: imem_rdata_i, ds: eff_ds};
            ds_pend_d = 1'b0;
          end
        end else if (!stall_i) begin
          id_ctl = IDC_BUBBLE;
        end
      end
      S_HOLD: begin
        if (!stall_i) begin
          id_ctl = IDC_LOAD;
          ds_pend_d = 1'b0;
          state_d = S_FETCH;
          // The buffered entry is the delay slot; the PC already moved past it, so jump now.
          if (br) begin
            pc_d = branch_target_address_i;
            redirect_pend_d = 1'b0;
          end
        end
      end
      default: state_d = S_RESET;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      pc_q <= RESET_PC;
      redirect_pend_q <= 1'b0;
      redirect_addr_q <= ZERO_WORD;
      ds_pend_q <= 1'b0;
      hold_pc_q <= ZERO_WORD;
      hold_inst_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      redirect_pend_q <= redirect_pend_d;
      redirect_addr_q <= redirect_addr_d;
      ds_pend_q <= ds_pend_d;
      hold_pc_q <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end
  if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
    .clk  (clk),
    .rst  (rst),
    .ctl_i(id_ctl),
    .d_i  (id_d),
    .q_o  (id_q)
  );
  assign imem_addr_o = pc_q;
  assign pc_o = pc_q;
  assign id_pc_o = id_q.pc;
  assign id_inst_o = id_q.inst;
  assign id_is_in_delayslot_o = id_q.ds;
endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core. It is the producer side of the decode interface. It owns the PC, drives a request/valid instruction-memory port, and delivers pc/inst/delay-slot flag to decode. It consumes decode's branch_flag/branch_target_address/next_inst_in_delayslot and the pipeline stall, and implements branch redirect after exactly one delay-slot instruction.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0000, instruction word driven to decode during bubbles

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset (`RstEnable)
stall_i  in  1  decode stage held (ctrl, incl. load-use stallreq); IF/ID must hold
branch_flag_i  in  1  decode resolved a taken branch/jump this cycle
branch_target_address_i  in  32  redirect target
next_inst_in_delayslot_i  in  1  next delivered instruction is a delay slot
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address, word aligned
imem_valid_i  in  1  data valid for the outstanding request (may be same cycle as req)
imem_rdata_i  in  32  instruction word
id_pc_o  out  32  PC of the instruction in decode
id_inst_o  out  32  instruction in decode
id_is_in_delayslot_o  out  1  decode instruction is a delay slot
pc_o  out  32  current fetch PC (debug)

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst). All state is updated on rising clk only.
- Reset (any cycle, including mid-fetch): state=S_RESET; pc=RESET_PC; imem_req_o=0; id_pc_o=0; id_inst_o=NOP_INST; id_is_in_delayslot_o=0; redirect_pend=0; ds_pend=0; hold buffer cleared. A late imem_valid_i after reset is ignored because no request is outstanding.
- FSM states:
  - S_RESET: req=0; next state is S_FETCH.
  - S_FETCH: req=1, addr=pc, both held stable until imem_valid_i.
    - valid & !stall_i: load IF/ID with {pc, rdata, ds_pend}; clear ds_pend; pc<=next_pc; stay in S_FETCH.
    - valid & stall_i: capture {pc, rdata} into the hold buffer; pc<=next_pc; go to S_HOLD.
    - No valid & !stall_i: IF/ID loads a bubble {0, NOP_INST, 0}. ds_pend persists across bubbles.
  - S_HOLD: req=0. When !stall_i: IF/ID loads the buffered entry with ds_pend, then clears ds_pend; go to S_FETCH.
- next_pc = redirect_pend ? redirect_addr : pc+4. Arithmetic is 32-bit and wraps at 0xFFFF_FFFC -> 0.
- Branch capture:
  - When branch_flag_i & !stall_i: redirect_pend<=1, redirect_addr<=branch_target_address_i, ds_pend<=next_inst_in_delayslot_i.
  - redirect_pend clears when the delay-slot fetch completes and next_pc is consumed.
  - Simultaneous case: branch_flag_i in the same cycle the delay-slot fetch completes uses the target directly as next_pc, and the delivered instruction carries delayslot=1.
- branch_flag_i is ignored while stall_i=1, because decode re-evaluates after the stall.
- stall_i with IF/ID holding keeps id_* unchanged.
- Latency: with zero-wait memory, an instruction at address A is on id_* the cycle after its req/valid cycle. Throughput is 1 instruction per cycle.

Decomposition:
- defines.v gains:
  - `ResetPC` default.
  - `IF_S_RESET/S_FETCH/S_HOLD` 2-bit state encodings.
  - Reused existing constants: `ZeroWord`, `Branch`, `InDelaySlot`, `Stop`, `RstEnable`.
- One sub-module, if_id_reg: the IF/ID register with load/hold/bubble control. The FSM, PC and redirect logic stay in if_fetch.

Test Plan:
1. rst high 2 cycles, then zero-wait memory -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; id_pc 0x0, 0x4, 0x8 one cycle later; delayslot=0.
2. While id_pc=0x8, pulse branch_flag=1, target=0x40, next_inst_in_delayslot=1 -> id gets 0xC with delayslot=1; next imem_addr=0x40; id gets 0x40 with delayslot=0.
3. stall_i=1 in the cycle 0x10 returns -> id_pc holds 0xC; req=0 in S_HOLD; stall drops -> id_pc=0x10 next cycle, then req addr 0x14.
4. Memory with 3-cycle wait -> addr held stable; id shows pc=0, inst=NOP_INST for 3 cycles; delayslot flag survives the bubbles after a branch.
5. Branch flag in the same cycle the delay-slot fetch returns (target 0x100) -> next req addr 0x100, not pc+4.
6. rst asserted while a fetch is outstanding -> next cycle req=0, pc=RESET_PC, id outputs at reset values; a stray imem_valid is ignored.
